// File: rtl/a2d_slave_model.sv
// Behavioural SPI slave modelling a multi-channel A/D converter.
// Each 16-bit frame returns the currently selected channel's value and
// receives the channel address to serve in the next frame.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI  SPI slave inputs, asynchronous to clk
//   MISO              SPI response bit (0 outside a frame)
//   wr_en, wr_sel,    channel value write port
//   wr_data
//   frame_done        one-clk pulse per completed frame
//   last_ch           channel served by the last completed frame
//   conv_cnt          completed-frame counter (wraps)
//   addr_err          sticky out-of-range channel address flag
module a2d_slave_model #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned RAMP_STEP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              wr_en,
    input  logic [2:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic [2:0]        last_ch,
    output logic [15:0]       conv_cnt,
    output logic              addr_err
);

    localparam int unsigned MAX_CH  = 8;
    localparam int unsigned FRAME_W = 16;
    // Only the low 14 received bits matter: the address sits in [13:11]
    // after a full frame and the two top command bits simply fall off.
    localparam int unsigned RX_W    = 14;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned JUST_SH = 12 - DATA_W;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [DATA_W-1:0] RAMP_INC = DATA_W'(RAMP_STEP);

    // WAIT_HIGH: after reset, wait until the synchronized SS_n is really
    // high so a select still held low from before reset cannot start a frame.
    typedef enum logic [1:0] {
        ST_WAIT_HIGH,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic ss_meta, ss_sync, ss_prev;
    logic sclk_meta, sclk_sync, sclk_prev;
    logic mosi_meta, mosi_sync;
    logic [1:0] flush;

    logic [FRAME_W-1:0] tx;
    logic [RX_W-1:0]    rx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [2:0]         cur_ch;
    logic [DATA_W-1:0]  ch_val [MAX_CH];

    logic        ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;
    logic        cur_ok_c, wr_ok_c, sel_bad_c;
    logic [11:0] served_c;
    logic        start_c, done_c;

    // Edge detection on synchronized inputs
    assign ss_fall_c   = ss_prev & ~ss_sync;
    assign ss_rise_c   = ~ss_prev & ss_sync;
    assign sclk_rise_c = ~sclk_prev & sclk_sync;
    assign sclk_fall_c = sclk_prev & ~sclk_sync;

    assign cur_ok_c  = (32'(cur_ch) < NUM_CH);
    assign wr_ok_c   = (32'(wr_sel) < NUM_CH);
    assign sel_bad_c = (32'(rx[13:11]) >= NUM_CH);

    // Channel value left-justified to 12 bits; invalid channels read as 0
    assign served_c = cur_ok_c ? (12'(ch_val[cur_ch]) << JUST_SH) : 12'd0;

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next-state and frame start/complete strobes
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_WAIT_HIGH: begin
                if (flush == 2'd3 && ss_prev) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_next = ST_ACTIVE;
                    start_c    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_c) begin
                    state_next = ST_IDLE;
                    done_c     = (bit_cnt == CNT_FULL);
                end
            end
            default: state_next = ST_WAIT_HIGH;
        endcase
    end

    // Synchronizers, shifters, channel storage and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta    <= 1'b1;
            ss_sync    <= 1'b1;
            ss_prev    <= 1'b1;
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            mosi_meta  <= 1'b0;
            mosi_sync  <= 1'b0;
            flush      <= 2'd0;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            cur_ch     <= 3'd0;
            MISO       <= 1'b0;
            frame_done <= 1'b0;
            last_ch    <= 3'd0;
            conv_cnt   <= 16'd0;
            addr_err   <= 1'b0;
            for (int i = 0; i < MAX_CH; i++) begin
                ch_val[i] <= '0;
            end
        end else begin
            ss_meta   <= SS_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;

            // Counts the cycles until the synchronizer holds real input
            if (flush != 2'd3) begin
                flush <= flush + 2'd1;
            end

            if (start_c) begin
                tx      <= {4'b0000, served_c};
                rx      <= '0;
                bit_cnt <= '0;
            end else if (state == ST_ACTIVE) begin
                // Edges past the 16th are ignored on receive
                if (sclk_rise_c && bit_cnt != CNT_FULL) begin
                    rx      <= {rx[RX_W-2:0], mosi_sync};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (sclk_fall_c) begin
                    tx <= {tx[FRAME_W-2:0], 1'b0};
                end
            end

            MISO       <= (state == ST_ACTIVE) ? tx[FRAME_W-1] : 1'b0;
            frame_done <= done_c;

            if (done_c) begin
                last_ch  <= cur_ch;
                conv_cnt <= conv_cnt + 16'd1;
                cur_ch   <= rx[13:11];
                if (sel_bad_c) begin
                    addr_err <= 1'b1;
                end
            end

            // Ramp first so a same-cycle write to the channel takes priority
            for (int i = 0; i < MAX_CH; i++) begin
                if (RAMP_STEP != 0 && done_c && cur_ok_c && cur_ch == 3'(i)) begin
                    ch_val[i] <= ch_val[i] + RAMP_INC;
                end
                if (wr_en && wr_ok_c && wr_sel == 3'(i)) begin
                    ch_val[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_a2d_slave_model.sv
// Directed bench for a2d_slave_model. Four instances share the SPI and
// write stimulus: default parameters, DATA_W=8, NUM_CH=4 and RAMP_STEP=0x100.
module tb_a2d_slave_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, SS_n, SCLK, MOSI, wr_en;
    logic [2:0]  wr_sel;
    logic [11:0] wr_data;

    logic        miso_m, fd_m, ae_m, miso_w, fd_w, ae_w;
    logic        miso_n, fd_n, ae_n, miso_r, fd_r, ae_r;
    logic [2:0]  lc_m, lc_w, lc_n, lc_r;
    logic [15:0] cc_m, cc_w, cc_n, cc_r;

    int n_tests = 0;
    int n_fail  = 0;

    int fdc_m = 0, fdc_w = 0, fdc_n = 0, fdc_r = 0;
    int fd_d_m, fd_d_w, fd_d_n, fd_d_r;
    logic [15:0] got_m, got_w, got_n, got_r;

    a2d_slave_model u_m (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_m),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .frame_done(fd_m), .last_ch(lc_m), .conv_cnt(cc_m), .addr_err(ae_m)
    );

    a2d_slave_model #(.DATA_W(8)) u_w8 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_w),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data[7:0]),
        .frame_done(fd_w), .last_ch(lc_w), .conv_cnt(cc_w), .addr_err(ae_w)
    );

    a2d_slave_model #(.NUM_CH(4)) u_n4 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .frame_done(fd_n), .last_ch(lc_n), .conv_cnt(cc_n), .addr_err(ae_n)
    );

    a2d_slave_model #(.RAMP_STEP(32'h100)) u_rp (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_r),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .frame_done(fd_r), .last_ch(lc_r), .conv_cnt(cc_r), .addr_err(ae_r)
    );

    // Count frame_done high cycles; a frame must add exactly one
    always @(negedge clk) begin
        if (fd_m) fdc_m++;
        if (fd_w) fdc_w++;
        if (fd_n) fdc_n++;
        if (fd_r) fdc_r++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [11:0] data);
        wr_sel  = sel;
        wr_data = data;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        tick(1);
    endtask

    // One SPI frame of nbits SCLK cycles; optional write lands on the load cycle
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input logic hook,
                             input logic [2:0] hsel, input logic [11:0] hdata);
        int s_m, s_w, s_n, s_r;
        s_m = fdc_m; s_w = fdc_w; s_n = fdc_n; s_r = fdc_r;
        got_m = '0; got_w = '0; got_n = '0; got_r = '0;
        SS_n = 1'b0;
        tick(2);
        if (hook) begin
            wr_sel  = hsel;
            wr_data = hdata;
            wr_en   = 1'b1;
        end
        tick(1);
        wr_en = 1'b0;
        tick(7);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            tick(5);
            got_m = {got_m[14:0], miso_m};
            got_w = {got_w[14:0], miso_w};
            got_n = {got_n[14:0], miso_n};
            got_r = {got_r[14:0], miso_r};
            SCLK = 1'b1;
            tick(10);
            SCLK = 1'b0;
            tick(5);
        end
        MOSI = 1'b0;
        tick(5);
        SS_n = 1'b1;
        tick(12);
        fd_d_m = fdc_m - s_m; fd_d_w = fdc_w - s_w;
        fd_d_n = fdc_n - s_n; fd_d_r = fdc_r - s_r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_tests++; if (miso_m !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b exp 0", miso_m); end
        n_tests++; if (fd_m !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b exp 0", fd_m); end
        n_tests++; if (lc_m !== 3'd0) begin n_fail++; $display("FAIL rst_last_ch: got %0d exp 0", lc_m); end
        n_tests++; if (cc_m !== 16'd0) begin n_fail++; $display("FAIL rst_conv_cnt: got %h exp 0000", cc_m); end
        n_tests++; if (ae_m !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err: got %b exp 0", ae_m); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_basic();
        do_reset();
        wr(3'd0, 12'hABC);
        wr(3'd3, 12'h123);
        spi_frame(16'h1800, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_m !== 16'h0ABC) begin n_fail++; $display("FAIL basic_miso_ch0: got %h exp 0abc", got_m); end
        n_tests++; if (lc_m !== 3'd0) begin n_fail++; $display("FAIL basic_last_ch0: got %0d exp 0", lc_m); end
        n_tests++; if (cc_m !== 16'd1) begin n_fail++; $display("FAIL basic_conv1: got %h exp 0001", cc_m); end
        n_tests++; if (fd_d_m !== 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d exp 1", fd_d_m); end
        n_tests++; if (got_w !== 16'h0BC0) begin n_fail++; $display("FAIL basic_w8_ch0: got %h exp 0bc0", got_w); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_m !== 16'h0123) begin n_fail++; $display("FAIL basic_miso_ch3: got %h exp 0123", got_m); end
        n_tests++; if (lc_m !== 3'd3) begin n_fail++; $display("FAIL basic_last_ch3: got %0d exp 3", lc_m); end
        n_tests++; if (cc_m !== 16'd2) begin n_fail++; $display("FAIL basic_conv2: got %h exp 0002", cc_m); end
    endtask

    task automatic test_data_w8();
        do_reset();
        wr(3'd1, 12'h0A5);
        spi_frame(16'h0800, 16, 1'b0, 3'd0, 12'h0);
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_w !== 16'h0A50) begin n_fail++; $display("FAIL w8_miso: got %h exp 0a50", got_w); end
        n_tests++; if (lc_w !== 3'd1) begin n_fail++; $display("FAIL w8_last_ch: got %0d exp 1", lc_w); end
        n_tests++; if (got_m !== 16'h00A5) begin n_fail++; $display("FAIL w12_miso: got %h exp 00a5", got_m); end
    endtask

    task automatic test_abort();
        do_reset();
        wr(3'd2, 12'h456);
        spi_frame(16'h1000, 16, 1'b0, 3'd0, 12'h0);
        spi_frame(16'h0000, 9, 1'b0, 3'd0, 12'h0);
        n_tests++; if (fd_d_m !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d exp 0", fd_d_m); end
        n_tests++; if (cc_m !== 16'd1) begin n_fail++; $display("FAIL abort_conv: got %h exp 0001", cc_m); end
        n_tests++; if (lc_m !== 3'd0) begin n_fail++; $display("FAIL abort_last_ch: got %0d exp 0", lc_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_m !== 16'h0456) begin n_fail++; $display("FAIL abort_next_miso: got %h exp 0456", got_m); end
        n_tests++; if (lc_m !== 3'd2) begin n_fail++; $display("FAIL abort_next_last_ch: got %0d exp 2", lc_m); end
        n_tests++; if (cc_m !== 16'd2) begin n_fail++; $display("FAIL abort_next_conv: got %h exp 0002", cc_m); end
    endtask

    task automatic test_addr_err();
        do_reset();
        wr(3'd6, 12'h777);
        spi_frame(16'h3000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (ae_n !== 1'b1) begin n_fail++; $display("FAIL adr_err_set: got %b exp 1", ae_n); end
        n_tests++; if (ae_m !== 1'b0) begin n_fail++; $display("FAIL adr_err_valid8: got %b exp 0", ae_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_n !== 16'h0000) begin n_fail++; $display("FAIL adr_invalid_data: got %h exp 0000", got_n); end
        n_tests++; if (got_m !== 16'h0777) begin n_fail++; $display("FAIL adr_valid_data: got %h exp 0777", got_m); end
        n_tests++; if (lc_n !== 3'd6) begin n_fail++; $display("FAIL adr_last_ch: got %0d exp 6", lc_n); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (ae_n !== 1'b1) begin n_fail++; $display("FAIL adr_err_sticky: got %b exp 1", ae_n); end
        do_reset();
        n_tests++; if (ae_n !== 1'b0) begin n_fail++; $display("FAIL adr_err_rst: got %b exp 0", ae_n); end
    endtask

    task automatic test_ramp();
        do_reset();
        wr(3'd2, 12'hF80);
        spi_frame(16'h1000, 16, 1'b0, 3'd0, 12'h0);
        spi_frame(16'h1000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_r !== 16'h0F80) begin n_fail++; $display("FAIL ramp_first: got %h exp 0f80", got_r); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_r !== 16'h0080) begin n_fail++; $display("FAIL ramp_wrap: got %h exp 0080", got_r); end
        n_tests++; if (got_m !== 16'h0F80) begin n_fail++; $display("FAIL ramp_static: got %h exp 0f80", got_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_r !== 16'h0100) begin n_fail++; $display("FAIL ramp_ch0: got %h exp 0100", got_r); end
    endtask

    task automatic test_write_at_load();
        do_reset();
        wr(3'd0, 12'h111);
        spi_frame(16'h0000, 16, 1'b1, 3'd0, 12'h222);
        n_tests++; if (got_m !== 16'h0111) begin n_fail++; $display("FAIL wload_old: got %h exp 0111", got_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (got_m !== 16'h0222) begin n_fail++; $display("FAIL wload_new: got %h exp 0222", got_m); end
    endtask

    task automatic test_wrap_and_reset();
        int s_m;
        do_reset();
        wr(3'd0, 12'hFFF);
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        force u_m.conv_cnt = 16'hFFFF;
        #1;
        release u_m.conv_cnt;
        spi_frame(16'h0800, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (cc_m !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap: got %h exp 0000", cc_m); end
        n_tests++; if (fd_d_m !== 1) begin n_fail++; $display("FAIL cnt_wrap_done: got %0d exp 1", fd_d_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (lc_m !== 3'd1) begin n_fail++; $display("FAIL pre_rst_last_ch: got %0d exp 1", lc_m); end
        // Mid-frame reset on a frame serving ch0 = 0xFFF
        s_m  = fdc_m;
        SS_n = 1'b0;
        tick(10);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1; tick(10);
            SCLK = 1'b0; tick(5);
        end
        n_tests++; if (miso_m !== 1'b1) begin n_fail++; $display("FAIL pre_rst_miso: got %b exp 1", miso_m); end
        rst = 1'b1;
        tick(1);
        n_tests++; if (miso_m !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b exp 0", miso_m); end
        n_tests++; if (lc_m !== 3'd0) begin n_fail++; $display("FAIL midrst_last_ch: got %0d exp 0", lc_m); end
        n_tests++; if (cc_m !== 16'd0) begin n_fail++; $display("FAIL midrst_conv: got %h exp 0000", cc_m); end
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            SCLK = 1'b1; tick(10);
            SCLK = 1'b0; tick(10);
        end
        SS_n = 1'b1;
        tick(12);
        n_tests++; if (fdc_m - s_m !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d exp 0", fdc_m - s_m); end
        n_tests++; if (cc_m !== 16'd0) begin n_fail++; $display("FAIL midrst_conv_after: got %h exp 0000", cc_m); end
        spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0);
        n_tests++; if (cc_m !== 16'd1) begin n_fail++; $display("FAIL postrst_conv: got %h exp 0001", cc_m); end
        n_tests++; if (got_m !== 16'h0000) begin n_fail++; $display("FAIL postrst_miso: got %h exp 0000", got_m); end
    endtask

    initial begin
        rst     = 1'b1;
        SS_n    = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 3'd0;
        wr_data = 12'h0;
        tick(1);
        test_reset();
        test_basic();
        test_data_w8();
        test_abort();
        test_addr_err();
        test_ramp();
        test_write_at_load();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/a2d_slave_model.md
A2D_SLAVE_MODEL -- requirements
Module: a2d_slave_model

Interface
REQ-001 Parameter NUM_CH, 8, number of channels (1..8).
REQ-002 Parameter DATA_W, 12, channel value width (8..12).
REQ-003 Parameter RAMP_STEP, 0, per-frame increment applied to the served channel value; 0 = static values.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 SS_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-008 SCLK  input  1  SPI clock, asynchronous to clk, at least 8 clk periods per SCLK half-period.
REQ-009 MOSI  input  1  SPI command data.
REQ-010 MISO  output  1  SPI response data.
REQ-011 wr_en  input  1  write strobe for a channel value.
REQ-012 wr_sel  input  3  channel index for the write.
REQ-013 wr_data  input  DATA_W  new channel value.
REQ-014 frame_done  output  1  one-clk pulse per completed 16-bit frame.
REQ-015 last_ch  output  3  channel served in the most recently completed frame.
REQ-016 conv_cnt  output  16  completed-frame counter.
REQ-017 addr_err  output  1  sticky flag: a channel address >= NUM_CH was received.

Function
REQ-018 SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized signals.
REQ-019 Frame start SHALL be a synchronized SS_n falling edge, which loads the 16-bit TX shifter with {4'b0000, value[cur_ch] left-justified to 12 bits, LSBs zero} and clears the bit counter.
REQ-020 MOSI SHALL be shifted into the RX shifter on each synchronized SCLK rising edge while SS_n is low; the bit counter counts 0..16 and saturates at 16.
REQ-021 The TX shifter SHALL shift left on each synchronized SCLK falling edge while SS_n is low; MISO = TX shifter MSB while SS_n is low, and 0 while SS_n is high.
REQ-022 A frame SHALL complete on the synchronized SS_n rising edge only if the bit counter equals 16; otherwise it is aborted.
REQ-023 On completion: frame_done pulses high for exactly 1 clk in the cycle after the rising edge is detected; last_ch <= cur_ch; conv_cnt increments, wrapping 0xFFFF -> 0; next cur_ch <= RX[13:11].
REQ-024 If RX[13:11] >= NUM_CH, addr_err SHALL set and stay set until reset; a frame served on an invalid channel returns data 0.
REQ-025 An aborted frame SHALL leave cur_ch, last_ch, conv_cnt, channel values and frame_done unchanged.
REQ-026 SCLK edges after the 16th within a frame SHALL be ignored for RX and shift zeros out of TX.
REQ-027 If RAMP_STEP != 0, a completed frame on a valid channel SHALL add RAMP_STEP to that channel value, modulo 2^DATA_W.
REQ-028 wr_en SHALL overwrite value[wr_sel] on the next clk edge; writes with wr_sel >= NUM_CH are ignored.
REQ-029 A write in the same cycle as frame-start load SHALL NOT affect the current frame (old value shifted); it applies from the next frame.
REQ-030 A write coinciding with a ramp update on the same channel: the write wins.

Reset
REQ-031 While rst is high: MISO=0, frame_done=0, last_ch=0, conv_cnt=0, addr_err=0, cur_ch=0, all channel values=0, shifters, bit counter and synchronizers cleared (SS_n sync flops to 1).
REQ-032 rst asserted mid-frame SHALL abort the frame; after release, the next frame requires a fresh SS_n falling edge.

Verification
REQ-033 Write ch0=0xABC, ch3=0x123; frame with MOSI cmd 0x1800 -> MISO 0x0ABC, last_ch=0, conv_cnt=1; next frame with cmd 0x0000 -> MISO 0x0123, last_ch=3.
REQ-034 DATA_W=8, ch1=0xA5 selected -> MISO 0x0A50.
REQ-035 SS_n raised after 9 SCLK cycles -> no frame_done, conv_cnt and cur_ch unchanged; next full frame serves the previously selected channel.
REQ-036 NUM_CH=4, cmd 0x3000 (ch6) -> addr_err=1; following frame MISO 0x0000; addr_err remains 1 until rst.
REQ-037 RAMP_STEP=0x100, ch2=0xF80 served 2 frames -> MISO 0x0F80 then 0x0080 (wrap).
REQ-038 rst pulse mid-frame -> all outputs 0 on next clk; conv_cnt 0xFFFF plus one frame -> 0x0000.
